// File: rtl/life_array_reader_if.sv
//==============================================================================
// Module      : life_array_reader_if
// Description : Bundle of the signals between the life-array reader, the life
//               array it scans and the logic that consumes its snapshots.
//                 start          - scan request (sampled only while idle)
//                 valo           - 16-bit quadrant word from the life array
//                 valo_selector  - quadrant index driven to the life array
//                 busy / done    - scan in progress / completion pulse
//                 board          - last completed snapshot {q3,q2,q1,q0}
//                 population     - live-cell count of board
//                 changed_mask   - per-quadrant change flags vs. previous
//                 stable         - whole board equals previous snapshot
//               Modport 'master' is the reader, 'slave' the environment.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface life_array_reader_if;
    logic        start;
    logic [15:0] valo;
    logic [1:0]  valo_selector;
    logic        busy;
    logic        done;
    logic [63:0] board;
    logic [6:0]  population;
    logic [3:0]  changed_mask;
    logic        stable;

    modport master (
        input  start,
        input  valo,
        output valo_selector,
        output busy,
        output done,
        output board,
        output population,
        output changed_mask,
        output stable
    );

    modport slave (
        output start,
        output valo,
        input  valo_selector,
        input  busy,
        input  done,
        input  board,
        input  population,
        input  changed_mask,
        input  stable
    );
endinterface

`default_nettype wire

// File: rtl/life_array_reader.sv
//==============================================================================
// Module      : life_array_reader
// Description : Scans the four 16-bit quadrants of an 8x8 life array through
//               a selector/read port with READ_LAT cycles of read latency,
//               then publishes an atomic snapshot together with its
//               population count, per-quadrant change mask and a stability
//               flag.
// Parameters  : READ_LAT - cycles from a selector change until valo is valid
//                          (legal range 0..3)
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-low reset
//               bus   - life_array_reader_if.master (see interface header)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module life_array_reader #(
    parameter int READ_LAT = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    life_array_reader_if.master bus
);

    localparam logic [1:0] C_LAT = READ_LAT[1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_sel;
    logic [1:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [63:0] r_board;
    logic [6:0]  r_pop;
    logic [3:0]  r_mask;
    logic        r_stable;
    logic        r_prev_valid;

    // Staging registers for quadrants 0..2; quadrant 3 is taken straight from
    // valo on the final capture so the snapshot publishes on that same edge.
    logic [15:0] r_q0;
    logic [15:0] r_q1;
    logic [15:0] r_q2;

    logic [63:0] w_new_board;
    logic [6:0]  w_pop;
    logic [3:0]  w_mask;

    assign w_new_board = {bus.valo, r_q2, r_q1, r_q0};

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 64; i++) begin
            w_pop = w_pop + {6'd0, w_new_board[i]};
        end
    end

    // Without a valid previous snapshot every quadrant counts as changed.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 4; i++) begin
            w_mask[i] = r_prev_valid ?
                        |(w_new_board[16*i +: 16] ^ r_board[16*i +: 16]) : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_sel        <= 2'd0;
            r_cnt        <= 2'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_board      <= '0;
            r_pop        <= '0;
            r_mask       <= '0;
            r_stable     <= 1'b0;
            r_prev_valid <= 1'b0;
            r_q0         <= '0;
            r_q1         <= '0;
            r_q2         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_WAIT;
                        r_sel   <= 2'd0;
                        r_cnt   <= 2'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == C_LAT) begin
                        if (r_sel == 2'd3) begin
                            r_state      <= S_DONE;
                            r_done       <= 1'b1;
                            r_board      <= w_new_board;
                            r_pop        <= w_pop;
                            r_mask       <= w_mask;
                            r_stable     <= r_prev_valid && (w_mask == 4'd0);
                            r_prev_valid <= 1'b1;
                        end else begin
                            case (r_sel)
                                2'd0:    r_q0 <= bus.valo;
                                2'd1:    r_q1 <= bus.valo;
                                default: r_q2 <= bus.valo;
                            endcase
                            r_sel <= r_sel + 2'd1;
                            r_cnt <= 2'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_sel   <= 2'd0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sel   <= 2'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valo_selector = r_sel;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.board         = r_board;
    assign bus.population    = r_pop;
    assign bus.changed_mask  = r_mask;
    assign bus.stable        = r_stable;

endmodule

`default_nettype wire
